// File: rtl/tx_burst_sched.sv
// Two-source round-robin burst scheduler: grants one source, starts a burst,
// waits for completion, then enforces a guard gap. Watchdog under TX_SCHED_TIMEOUT_EN.
module tx_burst_sched #(
  parameter int GUARD_CYC   = 16,
  parameter int TIMEOUT_CYC = 8000000,
  parameter int CNT_W       = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [1:0]       req,
  input  logic             tx_done,
  output logic [1:0]       gnt,
  output logic             tx_start,
  output logic             tx_abort,
  output logic             busy,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             err_timeout
);
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYC - 1);

  if (GUARD_CYC < 1 || GUARD_CYC > 255 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("tx_burst_sched: GUARD_CYC must be 1..255 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {IDLE, ARB, START, WAIT, GUARD} state_t;
  state_t state, state_d;

  logic [GW-1:0] gcnt;
  logic          last;      // index of the source served most recently
  logic          win_src;
  logic          guard_last;
  logic          wd_exp;
  logic          grant_go;

  // Source 0 wins unless only source 1 asks, or both ask and 0 went last.
  assign win_src    = ~(req[0] & (~req[1] | last));
  assign guard_last = (state == GUARD) && (gcnt == G_LAST);
  assign grant_go   = (state == ARB) && (state_d == START);

  assign tx_start = (state == START);
  assign busy     = (state == START) || (state == WAIT) || (state == GUARD);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (En) state_d = ARB;
      ARB:     if (!En) state_d = IDLE;
               else if (|req) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (tx_done || wd_exp) state_d = GUARD;
      GUARD:   if (guard_last) state_d = En ? ARB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= '0;
      last      <= 1'b1;
      burst_cnt <= '0;
      gcnt      <= '0;
    end else begin
      state <= state_d;
      if (grant_go) begin
        gnt  <= win_src ? 2'b10 : 2'b01;
        last <= win_src;
      end
      if (state == WAIT && state_d == GUARD) gnt <= '0;
      if (state == WAIT && tx_done) burst_cnt <= burst_cnt + 1'b1;
      gcnt <= (state == GUARD && !guard_last) ? gcnt + 1'b1 : '0;
    end
  end

`ifdef TX_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  logic [WW-1:0] wd_cnt;    // WAIT cycles already elapsed
  logic          idle_seen; // IDLE visited with no requests since last grant

  // A completing tx_done on the expiry cycle takes precedence over the abort.
  assign wd_exp = (state == WAIT) && !tx_done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt      <= '0;
      tx_abort    <= 1'b0;
      err_timeout <= 1'b0;
      idle_seen   <= 1'b0;
    end else begin
      wd_cnt   <= (state == WAIT && state_d == WAIT) ? wd_cnt + 1'b1 : '0;
      tx_abort <= wd_exp;
      if (wd_exp) err_timeout <= 1'b1;
      else if (grant_go && idle_seen) err_timeout <= 1'b0;
      if (state == IDLE && req == 2'b00) idle_seen <= 1'b1;
      else if (grant_go) idle_seen <= 1'b0;
    end
  end
`else
  assign wd_exp      = 1'b0;
  assign tx_abort    = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/tx_burst_sched.md
TX_BURST_SCHED -- requirements
Module: tx_burst_sched

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter GUARD_CYC, default 16, sets the idle gap between bursts in clk cycles (legal 1..255).
REQ-003 Parameter TIMEOUT_CYC, default 8000000, sets the per-burst watchdog limit in clk cycles (100 ms at 80 MHz).
REQ-004 Parameter CNT_W, default 16, sets the width of burst_cnt.
REQ-005 Port: clk  in  1  80 MHz system clock.
REQ-006 Port: rst  in  1  asynchronous active-low reset.
REQ-007 Port: En  in  1  global transmit enable, level.
REQ-008 Port: req  in  2  burst request per source (bit0 = source 0), level.
REQ-009 Port: tx_done  in  1  end-of-burst pulse from the transmit chain, one cycle.
REQ-010 Port: gnt  out  2  one-hot grant to the served source.
REQ-011 Port: tx_start  out  1  start pulse to the transmit chain, exactly one cycle wide.
REQ-012 Port: tx_abort  out  1  one-cycle pulse on watchdog expiry.
REQ-013 Port: busy  out  1  high in START, WAIT and GUARD.
REQ-014 Port: burst_cnt  out  CNT_W  count of completed bursts.
REQ-015 Port: err_timeout  out  1  sticky watchdog flag.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, ARB, START, WAIT, GUARD.
REQ-017 IDLE: go to ARB when En=1; otherwise hold.
REQ-018 ARB with En=0: go to IDLE; with no req bit set: hold.
REQ-019 ARB with any req bit set and En=1: go to START and register the one-hot gnt on the same edge.
REQ-020 Arbitration: a single requester wins; if both request, the source not served last wins (round-robin). The last-served pointer updates on entry to START.
REQ-021 tx_start SHALL be high exactly during the single START cycle; gnt is already valid in that cycle; the next state is WAIT.
REQ-022 Latency: req sampled high in ARB at edge n gives gnt and tx_start high in cycle n+1.
REQ-023 WAIT on tx_done: go to GUARD, increment burst_cnt (wraps modulo 2^CNT_W) and clear gnt on the same edge.
REQ-024 WAIT watchdog: when TIMEOUT_CYC cycles have elapsed in WAIT without tx_done, go to GUARD, pulse tx_abort for one cycle, set err_timeout, clear gnt and leave burst_cnt unchanged.
REQ-025 If tx_done coincides with watchdog expiry, tx_done SHALL win: count the burst, no abort, no error.
REQ-026 GUARD SHALL last exactly GUARD_CYC cycles, then go to ARB if En=1, else to IDLE.
REQ-027 tx_done outside WAIT SHALL be ignored.
REQ-028 Deasserting req after grant SHALL NOT affect the burst in progress.
REQ-029 En falling during START, WAIT or GUARD: the burst and guard SHALL complete, then the FSM goes to IDLE.
REQ-030 err_timeout SHALL clear only on reset, or on the ARB-to-START edge while En=1 and req=2'b00 was seen in IDLE (i.e. En re-cycled through IDLE).

Reset
REQ-031 On rst low: state=IDLE; gnt=0, tx_start=0, tx_abort=0, busy=0, burst_cnt=0, err_timeout=0, watchdog and guard counters=0; last-served pointer=1, so source 0 wins the first tie.
REQ-032 Reset mid-burst SHALL take effect immediately, with no tx_start or tx_abort emitted.

Configuration
REQ-033 Macro TX_SCHED_TIMEOUT_EN: when defined, the watchdog (REQ-024/025), tx_abort and err_timeout are implemented.
REQ-034 When TX_SCHED_TIMEOUT_EN is undefined, WAIT leaves only on tx_done, and tx_abort and err_timeout are tied to 0.

Verification
REQ-035 Reset, then En=1, req=2'b01 -> gnt=01 and tx_start one-cycle pulse two cycles after En; tx_done -> burst_cnt=1, gnt=00, busy high for 16 more cycles.
REQ-036 req=2'b11 held for 4 bursts -> grant order 01,10,01,10; each tx_start separated by at least GUARD_CYC cycles from the previous tx_done.
REQ-037 Macro defined, TIMEOUT_CYC=100, no tx_done -> tx_abort pulse at cycle 100 of WAIT, err_timeout=1, burst_cnt unchanged; macro undefined -> stays in WAIT indefinitely.
REQ-038 tx_done on the watchdog-expiry cycle -> burst_cnt increments, tx_abort=0; tx_done injected in ARB -> ignored.
REQ-039 En dropped during WAIT -> burst completes on tx_done, guard runs, FSM reaches IDLE, no further tx_start while req=11.
REQ-040 rst pulsed low during WAIT -> all outputs 0 within the same cycle; CNT_W=4, 17 bursts -> burst_cnt=1.
